// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART<->ALU glue: one-hot FSM encodings and ALU opcode constants.
// The ALU decodes the same opcode constants, so keep them in sync with it.
package uart_alu_interface_pkg;

    typedef enum logic [5:0] {
        ESPERA_A  = 6'b000001,
        ESPERA_B  = 6'b000010,
        ESPERA_OP = 6'b000100,
        ALU_WAIT  = 6'b001000,
        TX_START  = 6'b010000,
        TX_WAIT   = 6'b100000
    } state_t;

    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

    function automatic logic is_legal_opcode(input logic [5:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_legal_opcode = 1'b1;
            default:                        is_legal_opcode = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/uart_alu_interface_rise_edge_detect.sv
// Rising-edge detector: turns a held level (rx/tx done flags) into a single-cycle pulse.
module rise_edge_detect (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_sig,
    output logic o_pulse
);

    logic sig_q;

    always_ff @(posedge i_clock) begin
        if (!i_reset) sig_q <= 1'b0;
        else          sig_q <= i_sig;
    end

    assign o_pulse = i_sig & ~sig_q;

endmodule

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode from the UART receiver, latches the ALU result and starts tx.
// Define OPCODE_CHECK_EN to reject illegal opcodes with a one-cycle o_error strobe instead of transmitting.
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int WIDTH_WORD   = 8,
    parameter int WIDTH_OPCODE = 6
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_rx_done,
    input  logic [WIDTH_WORD-1:0]   i_data_rx,
    input  logic                    i_tx_done,
    input  logic [WIDTH_WORD-1:0]   i_alu_result,
    output logic [WIDTH_WORD-1:0]   o_operand_a,
    output logic [WIDTH_WORD-1:0]   o_operand_b,
    output logic [WIDTH_OPCODE-1:0] o_opcode,
    output logic [WIDTH_WORD-1:0]   o_data_tx,
    output logic                    o_tx_start,
    output logic                    o_error
);

    state_t                  state_q;
    logic [WIDTH_WORD-1:0]   operand_a_q;
    logic [WIDTH_WORD-1:0]   operand_b_q;
    logic [WIDTH_OPCODE-1:0] opcode_q;
    logic [WIDTH_WORD-1:0]   data_tx_q;
    logic                    tx_start_q;
    logic                    rx_ev;
    logic                    tx_ev;

    rise_edge_detect u_rx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_sig   (i_rx_done),
        .o_pulse (rx_ev)
    );

    rise_edge_detect u_tx_edge (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_sig   (i_tx_done),
        .o_pulse (tx_ev)
    );

`ifdef OPCODE_CHECK_EN
    logic error_q;
    assign o_error = error_q;
`else
    assign o_error = 1'b0;
`endif

    // tx_start_q is raised on the ALU_WAIT->TX_START edge so it is high exactly while in TX_START.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            state_q     <= ESPERA_A;
            operand_a_q <= '0;
            operand_b_q <= '0;
            opcode_q    <= '0;
            data_tx_q   <= '0;
            tx_start_q  <= 1'b0;
`ifdef OPCODE_CHECK_EN
            error_q     <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
`ifdef OPCODE_CHECK_EN
            error_q    <= 1'b0;
`endif
            case (state_q)
                ESPERA_A: if (rx_ev) begin
                    operand_a_q <= i_data_rx;
                    state_q     <= ESPERA_B;
                end
                ESPERA_B: if (rx_ev) begin
                    operand_b_q <= i_data_rx;
                    state_q     <= ESPERA_OP;
                end
                ESPERA_OP: if (rx_ev) begin
`ifdef OPCODE_CHECK_EN
                    if (!is_legal_opcode(i_data_rx[WIDTH_OPCODE-1:0])) begin
                        error_q <= 1'b1;
                        state_q <= ESPERA_A;
                    end else
`endif
                    begin
                        opcode_q <= i_data_rx[WIDTH_OPCODE-1:0];
                        state_q  <= ALU_WAIT;
                    end
                end
                ALU_WAIT: begin
                    data_tx_q  <= i_alu_result;
                    tx_start_q <= 1'b1;
                    state_q    <= TX_START;
                end
                TX_START: state_q <= TX_WAIT;
                TX_WAIT:  if (tx_ev) state_q <= ESPERA_A;
                default:  state_q <= ESPERA_A;
            endcase
        end
    end

    assign o_operand_a = operand_a_q;
    assign o_operand_b = operand_b_q;
    assign o_opcode    = opcode_q;
    assign o_data_tx   = data_tx_q;
    assign o_tx_start  = tx_start_q;

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed bench for uart_alu_interface; the external ALU is modelled as A+B.
module tb_uart_alu_interface;
    import uart_alu_interface_pkg::*;

    logic       i_clock = 1'b0;
    logic       i_reset;
    logic       i_rx_done;
    logic [7:0] i_data_rx;
    logic       i_tx_done;
    logic [7:0] i_alu_result;
    logic [7:0] o_operand_a;
    logic [7:0] o_operand_b;
    logic [5:0] o_opcode;
    logic [7:0] o_data_tx;
    logic       o_tx_start;
    logic       o_error;

    int n_tests = 0;
    int n_fail  = 0;

    uart_alu_interface #(.WIDTH_WORD(8), .WIDTH_OPCODE(6)) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_rx_done    (i_rx_done),
        .i_data_rx    (i_data_rx),
        .i_tx_done    (i_tx_done),
        .i_alu_result (i_alu_result),
        .o_operand_a  (o_operand_a),
        .o_operand_b  (o_operand_b),
        .o_opcode     (o_opcode),
        .o_data_tx    (o_data_tx),
        .o_tx_start   (o_tx_start),
        .o_error      (o_error)
    );

    always #5 i_clock = ~i_clock;

    assign i_alu_result = o_operand_a + o_operand_b;

    task automatic step();
        @(posedge i_clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] data, input int hold);
        i_data_rx = data;
        i_rx_done = 1'b1;
        repeat (hold) step();
        i_rx_done = 1'b0;
        step();
    endtask

    task automatic pulse_tx_done();
        i_tx_done = 1'b1;
        step();
        i_tx_done = 1'b0;
        step();
    endtask

    task automatic do_reset();
        i_reset = 1'b0;
        step();
        i_reset = 1'b1;
    endtask

    initial begin
        i_reset   = 1'b0;
        i_rx_done = 1'b0;
        i_data_rx = 8'h00;
        i_tx_done = 1'b0;
        step();
        step();
        i_reset = 1'b1;

        check("rst_a",     o_operand_a, 8'h00);
        check("rst_b",     o_operand_b, 8'h00);
        check("rst_op",    o_opcode,    6'h00);
        check("rst_tx",    o_data_tx,   8'h00);
        check("rst_start", o_tx_start,  1'b0);
        check("rst_err",   o_error,     1'b0);
        check("rst_state", 32'(dut.state_q), 32'(ESPERA_A));

        // 1: basic ADD, tx_start timing relative to the opcode capture edge
        send_byte(8'h05, 1);
        send_byte(8'h03, 1);
        i_data_rx = 8'h20;
        i_rx_done = 1'b1;
        step();
        check("t1_op",       o_opcode,   6'h20);
        check("t1_start_t0", o_tx_start, 1'b0);
        i_rx_done = 1'b0;
        step();
        check("t1_tx",       o_data_tx,  8'h08);
        check("t1_start_t1", o_tx_start, 1'b1);
        step();
        check("t1_start_t2", o_tx_start, 1'b0);
        check("t1_state_w",  32'(dut.state_q), 32'(TX_WAIT));
        pulse_tx_done();
        check("t1_state_a",  32'(dut.state_q), 32'(ESPERA_A));

        // 2: long-held rx_done yields a single capture
        do_reset();
        send_byte(8'h7A, 16);
        check("t2_a",     o_operand_a, 8'h7A);
        check("t2_b",     o_operand_b, 8'h00);
        check("t2_state", 32'(dut.state_q), 32'(ESPERA_B));

        // 3: mid-sequence reset discards partial operands
        do_reset();
        send_byte(8'h11, 1);
        check("t3_a_pre", o_operand_a, 8'h11);
        do_reset();
        check("t3_a",     o_operand_a, 8'h00);
        check("t3_b",     o_operand_b, 8'h00);
        check("t3_op",    o_opcode,    6'h00);
        check("t3_tx",    o_data_tx,   8'h00);
        check("t3_state", 32'(dut.state_q), 32'(ESPERA_A));
        send_byte(8'h02, 1);
        send_byte(8'h04, 1);
        send_byte(8'h20, 1);
        check("t3_a2",    o_operand_a, 8'h02);
        check("t3_b2",    o_operand_b, 8'h04);
        check("t3_tx2",   o_data_tx,   8'h06);
        check("t3_start", o_tx_start,  1'b1);
        step();
        pulse_tx_done();

        // 4: rx during TX_WAIT is dropped
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        send_byte(8'h20, 1);
        step();
        check("t4_state_w", 32'(dut.state_q), 32'(TX_WAIT));
        send_byte(8'h99, 1);
        check("t4_a_hold",  o_operand_a, 8'h01);
        check("t4_b_hold",  o_operand_b, 8'h02);
        check("t4_state_w2", 32'(dut.state_q), 32'(TX_WAIT));
        pulse_tx_done();
        check("t4_state_a", 32'(dut.state_q), 32'(ESPERA_A));
        send_byte(8'h44, 1);
        check("t4_a_new",   o_operand_a, 8'h44);

        // 6: tx_done while in ESPERA_B is ignored; opcode upper bits dropped
        pulse_tx_done();
        check("t6_state_b", 32'(dut.state_q), 32'(ESPERA_B));
        send_byte(8'h07, 1);
        check("t6_b",       o_operand_b, 8'h07);
        check("t6_state_op", 32'(dut.state_q), 32'(ESPERA_OP));
        send_byte(8'hE2, 1);
        check("t6_op",      o_opcode,    6'h22);
        check("t6_tx",      o_data_tx,   8'h4B);
        check("t6_start",   o_tx_start,  1'b1);
        step();
        pulse_tx_done();

        // 5: illegal opcode 0x3F
        do_reset();
        send_byte(8'h01, 1);
        send_byte(8'h02, 1);
        i_data_rx = 8'h3F;
        i_rx_done = 1'b1;
        step();
`ifdef OPCODE_CHECK_EN
        check("t5_err",     o_error,    1'b1);
        check("t5_op_hold", o_opcode,   6'h00);
        check("t5_state",   32'(dut.state_q), 32'(ESPERA_A));
        i_rx_done = 1'b0;
        step();
        check("t5_err_clr", o_error,    1'b0);
        check("t5_nostart", o_tx_start, 1'b0);
        step();
        check("t5_nostart2", o_tx_start, 1'b0);
`else
        check("t5_err",   o_error,  1'b0);
        check("t5_op",    o_opcode, 6'h3F);
        i_rx_done = 1'b0;
        step();
        check("t5_start", o_tx_start, 1'b1);
        check("t5_tx",    o_data_tx,  8'h03);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
